watch_time_setter: RTL
======================

# watch_time_setter

Timekeeping and time-setting datapath for Watch mode. Sits directly downstream of the command decoder and consumes its up/down/left/right pulses. It keeps an HH:MM:SS count driven by an internal 1 Hz prescaler and lets the user select a field with a cursor and adjust it with wrap-around. Its outputs feed the FND display formatter.

## Interface
Parameters:
- TICK_COUNT, default 100_000_000: clk cycles per second. Must be even and ≥ 4.
- RESET_HOUR, default 12: hour value loaded on reset (0–23).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  1 = Watch mode active. 0 = all command pulses ignored.
- i_up_pulse  in  1  one-cycle increment request.
- i_down_pulse  in  1  one-cycle decrement request.
- i_left_pulse  in  1  one-cycle cursor-left request.
- i_right_pulse  in  1  one-cycle cursor-right request.
- o_hour  out  5  hours, 0–23.
- o_min  out  6  minutes, 0–59.
- o_sec  out  6  seconds, 0–59.
- o_cursor  out  2  field selector: 0 = NONE, 1 = SEC, 2 = MIN, 3 = HOUR.
- o_edit  out  1  1 when o_cursor ≠ NONE.
- o_blink  out  1  blink phase for the selected field. 0 when not editing.

## Operation
- Reset values:
  - o_hour = RESET_HOUR; o_min = 0; o_sec = 0.
  - o_cursor = NONE; o_edit = 0; o_blink = 0.
  - Prescaler = 0; blink counter = 0.
- Cursor state machine, 4 states:
  - i_right_pulse steps NONE→SEC→MIN→HOUR→NONE.
  - i_left_pulse steps NONE→HOUR→MIN→SEC→NONE.
  - Left and right asserted in the same cycle: cursor unchanged.
- Command priority within one cycle:
  - A left or right pulse in the cycle means up/down are ignored in that cycle.
  - Up and down asserted together: no change.
- Up/down in NONE: ignored.
- Up/down in SEC, MIN or HOUR: the selected field changes by ±1 modulo its range.
  - SEC/MIN: 59+1 → 0, 0−1 → 59.
  - HOUR: 23+1 → 0, 0−1 → 23.
  - No carry or borrow into neighbouring fields while editing.
- Running (cursor NONE):
  - Prescaler counts 0..TICK_COUNT−1, then wraps to 0.
  - On the cycle the prescaler equals TICK_COUNT−1, sec increments.
  - Carry chain: sec 59→0 with min+1; min 59→0 with hour+1; hour 23→0.
  - 23:59:59 → 00:00:00.
- Editing (cursor ≠ NONE):
  - Prescaler is held at 0 and time does not advance.
  - On return to NONE, counting restarts from prescaler 0, so the first tick comes TICK_COUNT cycles after exit.
- Blink:
  - While editing, the blink counter counts 0..TICK_COUNT/2−1 and toggles o_blink on wrap.
  - Entering edit from NONE sets o_blink = 1 and clears the blink counter.
  - Leaving edit clears both the blink counter and o_blink.
  - Moving the cursor between fields or adjusting a field also restarts the blink with o_blink = 1 and the counter cleared.
- i_enable = 0:
  - Cursor is forced to NONE on the next edge; blink is cleared.
  - All pulses are ignored.
  - Time keeps running normally.

## Timing
- All outputs are registered.
- A pulse sampled at edge N is reflected on the outputs after edge N, a latency of 1 cycle.
- A new pulse may arrive every cycle, and each is processed independently.
- rst asserted mid-edit or mid-count: all state returns to its reset values on the next edge, and rst has priority over every other input.
- A tick and a cursor-entry pulse in the same cycle: the cursor pulse wins, no increment occurs, and the prescaler goes to 0.
- o_edit is combinationally equal to (o_cursor ≠ 0), derived from the cursor register.

## Test plan
All scenarios use TICK_COUNT = 10.
- **Reset and counting:** reset, then run 10 cycles → 12:00:01. After 600 cycles total → 12:01:00.
- **Midnight rollover:** preset 23:59:59 via edit, return to NONE, wait 10 cycles → 00:00:00.
- **Cursor cycling:**
  - Right ×4 → o_cursor 1, 2, 3, 0.
  - Left ×1 from NONE → 3.
  - Left and right together → unchanged.
- **Field wrap:**
  - SEC at 59, up → 0, with no minute change.
  - HOUR at 0, down → 23.
  - Up and down together → no change.
- **Edit freeze:** enter SEC, wait 50 cycles → time unchanged, o_blink toggles every 5 cycles starting at 1. Exit → first tick exactly 10 cycles later.
- **Disable and reset:**
  - While in MIN, drop i_enable → cursor 0 next cycle, up pulses ignored, counting continues.
  - Assert rst mid-count → 12:00:00, cursor 0, o_blink 0.

Source files
------------

// File: rtl/watch_time_setter.sv
// Watch-mode timekeeper: HH:MM:SS driven by a 1 Hz prescaler, with a cursor
// that freezes time and lets the user adjust one field with wrap-around.
module watch_time_setter #(
  parameter int TICK_COUNT = 100_000_000,
  parameter int RESET_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_up_pulse,
  input  logic       i_down_pulse,
  input  logic       i_left_pulse,
  input  logic       i_right_pulse,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_cursor,
  output logic       o_edit,
  output logic       o_blink
);

  localparam int PRESC_W = $clog2(TICK_COUNT);
  localparam int BLINK_W = $clog2(TICK_COUNT / 2);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_COUNT - 1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(TICK_COUNT / 2 - 1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = {BLINK_W{1'b0}};
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [4:0]         HOUR_INIT  = 5'(RESET_HOUR);

  typedef enum logic [1:0] {
    CUR_NONE = 2'd0,
    CUR_SEC  = 2'd1,
    CUR_MIN  = 2'd2,
    CUR_HOUR = 2'd3
  } cursor_e;

  function automatic logic [5:0] wrap60(input logic [5:0] v, input logic dec);
    logic [5:0] r;
    if (dec) r = (v == 6'd0)  ? 6'd59 : v - 6'd1;
    else     r = (v == 6'd59) ? 6'd0  : v + 6'd1;
    return r;
  endfunction

  function automatic logic [4:0] wrap24(input logic [4:0] v, input logic dec);
    logic [4:0] r;
    if (dec) r = (v == 5'd0)  ? 5'd23 : v - 5'd1;
    else     r = (v == 5'd23) ? 5'd0  : v + 5'd1;
    return r;
  endfunction

  cursor_e              cursor_r, cursor_nxt_s;
  logic [4:0]           hour_r, hour_nxt_s;
  logic [5:0]           min_r, min_nxt_s;
  logic [5:0]           sec_r, sec_nxt_s;
  logic [PRESC_W-1:0]   presc_r, presc_nxt_s;
  logic [BLINK_W-1:0]   blink_cnt_r, blink_cnt_nxt_s;
  logic                 blink_r, blink_nxt_s;
  logic                 move_s, adj_s, run_s, restart_s;

  // Next-state: cursor stepping, time count / field adjust, blink phase
  always_comb begin
    cursor_nxt_s    = cursor_r;
    hour_nxt_s      = hour_r;
    min_nxt_s       = min_r;
    sec_nxt_s       = sec_r;
    presc_nxt_s     = PRESC_ZERO;
    blink_cnt_nxt_s = BLINK_ZERO;
    blink_nxt_s     = 1'b0;
    move_s          = i_left_pulse | i_right_pulse;

    if (!i_enable) begin
      cursor_nxt_s = CUR_NONE;
    end else if (i_left_pulse && i_right_pulse) begin
      cursor_nxt_s = cursor_r;
    end else if (i_right_pulse) begin
      case (cursor_r)
        CUR_NONE: cursor_nxt_s = CUR_SEC;
        CUR_SEC:  cursor_nxt_s = CUR_MIN;
        CUR_MIN:  cursor_nxt_s = CUR_HOUR;
        default:  cursor_nxt_s = CUR_NONE;
      endcase
    end else if (i_left_pulse) begin
      case (cursor_r)
        CUR_NONE: cursor_nxt_s = CUR_HOUR;
        CUR_HOUR: cursor_nxt_s = CUR_MIN;
        CUR_MIN:  cursor_nxt_s = CUR_SEC;
        default:  cursor_nxt_s = CUR_NONE;
      endcase
    end else begin
      cursor_nxt_s = cursor_r;
    end

    adj_s = i_enable && !move_s && (i_up_pulse ^ i_down_pulse) && (cursor_r != CUR_NONE);
    // A cursor-entry pulse on the tick cycle suppresses the tick
    run_s = (cursor_r == CUR_NONE) && (cursor_nxt_s == CUR_NONE);

    if (run_s) begin
      if (presc_r == PRESC_LAST) begin
        presc_nxt_s = PRESC_ZERO;
        sec_nxt_s   = wrap60(sec_r, 1'b0);
        if (sec_r == 6'd59) begin
          min_nxt_s = wrap60(min_r, 1'b0);
          if (min_r == 6'd59) begin
            hour_nxt_s = wrap24(hour_r, 1'b0);
          end else begin
            hour_nxt_s = hour_r;
          end
        end else begin
          min_nxt_s = min_r;
        end
      end else begin
        presc_nxt_s = presc_r + PRESC_ONE;
      end
    end else if (adj_s) begin
      case (cursor_r)
        CUR_SEC:  sec_nxt_s  = wrap60(sec_r, i_down_pulse);
        CUR_MIN:  min_nxt_s  = wrap60(min_r, i_down_pulse);
        CUR_HOUR: hour_nxt_s = wrap24(hour_r, i_down_pulse);
        default:  sec_nxt_s  = sec_r;
      endcase
    end else begin
      presc_nxt_s = PRESC_ZERO;
    end

    restart_s = (cursor_nxt_s != CUR_NONE) && ((cursor_nxt_s != cursor_r) || adj_s);
    if (cursor_nxt_s == CUR_NONE) begin
      blink_cnt_nxt_s = BLINK_ZERO;
      blink_nxt_s     = 1'b0;
    end else if (restart_s) begin
      blink_cnt_nxt_s = BLINK_ZERO;
      blink_nxt_s     = 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_nxt_s = BLINK_ZERO;
      blink_nxt_s     = ~blink_r;
    end else begin
      blink_cnt_nxt_s = blink_cnt_r + BLINK_ONE;
      blink_nxt_s     = blink_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_r    <= CUR_NONE;
      hour_r      <= HOUR_INIT;
      min_r       <= 6'd0;
      sec_r       <= 6'd0;
      presc_r     <= PRESC_ZERO;
      blink_cnt_r <= BLINK_ZERO;
      blink_r     <= 1'b0;
    end else begin
      cursor_r    <= cursor_nxt_s;
      hour_r      <= hour_nxt_s;
      min_r       <= min_nxt_s;
      sec_r       <= sec_nxt_s;
      presc_r     <= presc_nxt_s;
      blink_cnt_r <= blink_cnt_nxt_s;
      blink_r     <= blink_nxt_s;
    end
  end

  assign o_hour   = hour_r;
  assign o_min    = min_r;
  assign o_sec    = sec_r;
  assign o_cursor = cursor_r;
  assign o_edit   = (cursor_r != CUR_NONE);
  assign o_blink  = blink_r;

endmodule
